// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC and the instruction SRAM read port, feeds {inst, pc} to decode.
// Optional macro IF_INST_BUF_EN adds an instruction buffer so the SRAM stays idle during decode stalls.
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'hBFC0_0000,
  localparam int BR_BUS_WD       = 33,
  localparam int FS_TO_DS_BUS_WD = 64
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       ds_allowin,
  input  logic [BR_BUS_WD-1:0]       br_bus,
  output logic                       fs_to_ds_valid,
  output logic [FS_TO_DS_BUS_WD-1:0] fs_to_ds_bus,
  output logic                       inst_sram_en,
  output logic [3:0]                 inst_sram_wen,
  output logic [31:0]                inst_sram_addr,
  output logic [31:0]                inst_sram_wdata,
  input  logic [31:0]                inst_sram_rdata
);

  // Handshake: an instruction moves IF->ID on a cycle where fs_to_ds_valid && ds_allowin;
  // until then the bus is held unchanged. A fetch is accepted whenever to_fs_valid && fs_allowin.

  logic        br_taken;
  logic [31:0] br_target;
  assign {br_taken, br_target} = br_bus;

  logic        to_fs_valid;
  logic [31:0] seq_pc;
  logic [31:0] nextpc;
  logic        fs_ready_go;
  logic        fs_allowin;
  logic        fs_accept;
  logic        fs_stall;

  logic        fs_valid;
  logic [31:0] fs_pc;
  logic [31:0] fs_inst;
  logic        br_pend;
  logic [31:0] br_pend_target;

  assign to_fs_valid = !reset;
  assign seq_pc      = fs_pc + 32'd4;

  // A redirect held from an earlier stalled cycle outranks a branch seen this cycle.
  always_comb begin
    nextpc = seq_pc;
    if (br_pend) begin
      nextpc = br_pend_target;
    end else if (br_taken) begin
      nextpc = br_target;
    end
  end

  assign fs_ready_go    = 1'b1;
  assign fs_allowin     = !fs_valid || (fs_ready_go && ds_allowin);
  assign fs_to_ds_valid = fs_valid && fs_ready_go;
  assign fs_accept      = to_fs_valid && fs_allowin;
  assign fs_stall       = fs_valid && !ds_allowin;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fs_valid <= 1'b0;
      fs_pc    <= RESET_PC - 32'd4;
    end else if (fs_accept) begin
      fs_valid <= 1'b1;
      fs_pc    <= nextpc;
    end
  end

  // The first target seen while IF cannot fetch is kept until a fetch consumes it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      br_pend        <= 1'b0;
      br_pend_target <= 32'h0;
    end else if (fs_accept) begin
      br_pend        <= 1'b0;
    end else if (br_taken && !br_pend) begin
      br_pend        <= 1'b1;
      br_pend_target <= br_target;
    end
  end

`ifdef IF_INST_BUF_EN
  logic        buf_valid;
  logic [31:0] inst_buf;

  // rdata is only valid the cycle after a request, so capture it on the first stalled cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      buf_valid <= 1'b0;
      inst_buf  <= 32'h0;
    end else if (fs_allowin) begin
      buf_valid <= 1'b0;
    end else if (fs_valid && !buf_valid && !ds_allowin) begin
      buf_valid <= 1'b1;
      inst_buf  <= inst_sram_rdata;
    end
  end

  assign fs_inst        = buf_valid ? inst_buf : inst_sram_rdata;
  assign inst_sram_en   = fs_accept;
  assign inst_sram_addr = reset ? RESET_PC : nextpc;
`else
  // Without a buffer the held instruction is re-read every stalled cycle.
  assign fs_inst        = inst_sram_rdata;
  assign inst_sram_en   = fs_accept || (to_fs_valid && fs_stall);
  assign inst_sram_addr = reset    ? RESET_PC :
                          fs_stall ? fs_pc    : nextpc;
`endif

  assign inst_sram_wen   = 4'h0;
  assign inst_sram_wdata = 32'h0;
  assign fs_to_ds_bus    = {fs_inst, fs_pc};

endmodule
